// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller: phase encoding, lamp
// patterns and small phase-sequencing helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic state_t next_phase(state_t s);
    case (s)
      NS_GREEN:  next_phase = NS_YELLOW;
      NS_YELLOW: next_phase = ALLRED_A;
      ALLRED_A:  next_phase = EW_GREEN;
      EW_GREEN:  next_phase = EW_YELLOW;
      EW_YELLOW: next_phase = ALLRED_B;
      default:   next_phase = NS_GREEN;
    endcase
  endfunction

  function automatic logic is_green(state_t s);
    is_green = (s == NS_GREEN) || (s == EW_GREEN);
  endfunction

  // Returns {ns_lamp, ew_lamp}.
  function automatic logic [5:0] lamp_decode(state_t s);
    case (s)
      NS_GREEN:  lamp_decode = {LAMP_G, LAMP_R};
      NS_YELLOW: lamp_decode = {LAMP_Y, LAMP_R};
      EW_GREEN:  lamp_decode = {LAMP_R, LAMP_G};
      EW_YELLOW: lamp_decode = {LAMP_R, LAMP_Y};
      ALLRED_A,
      ALLRED_B:  lamp_decode = {LAMP_R, LAMP_R};
      default:   lamp_decode = {LAMP_G, LAMP_R};
    endcase
  endfunction

endpackage

// File: rtl/tick_edge_det.sv
// Samples the divider's slow square wave and emits a one-clk strobe on
// each rising edge.
module tick_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_clk,
  output logic tick
);

  logic slow_q;

  // slow_q resets high so a wave already high at reset release is not an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slow_q <= 1'b1;
      tick   <= 1'b0;
    end else begin
      slow_q <= slow_clk;
      tick   <= slow_clk & ~slow_q;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road light sequencer driven by 1 s ticks, with a seconds-remaining
// countdown and a latched pedestrian request that shortens the green.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned T_GREEN     = 25,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 2,
  parameter int unsigned T_GREEN_MIN = 5,
  parameter int unsigned CW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          slow_clk,
  input  logic          ped_req,
  output logic [2:0]    ns_lamp,
  output logic [2:0]    ew_lamp,
  output logic [CW-1:0] remain,
  output logic          ped_pend,
  output logic          tick
);

  localparam logic [CW-1:0] DUR_G   = CW'(T_GREEN);
  localparam logic [CW-1:0] DUR_Y   = CW'(T_YELLOW);
  localparam logic [CW-1:0] DUR_AR  = CW'(T_ALLRED);
  localparam logic [CW-1:0] DUR_MIN = CW'(T_GREEN_MIN);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t        state, state_n;
  logic [CW-1:0] remain_n;
  logic          ped_n;
  logic          enter_allred;
  logic [5:0]    lamps_n;

  function automatic logic [CW-1:0] dur_of(state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   dur_of = DUR_G;
      NS_YELLOW, EW_YELLOW: dur_of = DUR_Y;
      default:              dur_of = DUR_AR;
    endcase
  endfunction

  tick_edge_det u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .slow_clk (slow_clk),
    .tick     (tick)
  );

  always_comb begin
    state_n      = state;
    remain_n     = remain;
    enter_allred = 1'b0;
    if (tick) begin
      if (remain == ONE) begin
        state_n      = next_phase(state);
        remain_n     = dur_of(state_n);
        enter_allred = (state_n == ALLRED_A) || (state_n == ALLRED_B);
      end else if (is_green(state) && ped_pend && (remain > DUR_MIN)) begin
        remain_n = DUR_MIN;
      end else begin
        remain_n = remain - ONE;
      end
    end
    // Unused encodings recover immediately, without waiting for a tick
    if (!(state inside {NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B})) begin
      state_n      = NS_GREEN;
      remain_n     = DUR_G;
      enter_allred = 1'b0;
    end
    ped_n   = ped_req | (ped_pend & ~enter_allred);
    lamps_n = lamp_decode(state_n);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= NS_GREEN;
      remain   <= DUR_G;
      ns_lamp  <= LAMP_G;
      ew_lamp  <= LAMP_R;
      ped_pend <= 1'b0;
    end else begin
      state    <= state_n;
      remain   <= remain_n;
      ns_lamp  <= lamps_n[5:3];
      ew_lamp  <= lamps_n[2:0];
      ped_pend <= ped_n;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: vector table, directed corner
// sequences and randomized pedestrian/reset traffic against a phase model.
module tb_traffic_light_ctrl;

  localparam int unsigned TG  = 4;
  localparam int unsigned TY  = 2;
  localparam int unsigned TA  = 1;
  localparam int unsigned TGM = 2;
  localparam int unsigned CW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          slow_clk = 1'b0;
  logic          ped_req = 1'b0;
  logic [2:0]    ns_lamp, ew_lamp;
  logic [CW-1:0] remain;
  logic          ped_pend, tick;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_GREEN_MIN(TGM), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .ped_req(ped_req),
    .ns_lamp(ns_lamp), .ew_lamp(ew_lamp), .remain(remain),
    .ped_pend(ped_pend), .tick(tick)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slow_clk: toggles every 4 clk while running, else holds slow_hold
  bit   slow_run = 1'b0;
  logic slow_hold = 1'b0;
  int   slow_cnt = 0;
  always @(negedge clk) begin
    if (!slow_run) begin
      slow_clk = slow_hold;
      slow_cnt = 0;
    end else if (slow_cnt == 3) begin
      slow_clk = ~slow_clk;
      slow_cnt = 0;
    end else begin
      slow_cnt++;
    end
  end

  // Reference model: phase index 0..5 around the ring, seconds left, request latch
  int         dur [6] = '{TG, TY, TA, TG, TY, TA};
  logic [2:0] m_ns[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] m_ew[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_phase = 0;
  int m_remain = TG;
  bit m_ped = 1'b0, m_tick = 1'b0, m_prev_slow = 1'b1;

  always @(posedge clk) begin
    bit entered;
    entered = 1'b0;
    if (!rst_n) begin
      m_phase = 0; m_remain = TG; m_ped = 1'b0; m_tick = 1'b0; m_prev_slow = 1'b1;
    end else begin
      if (m_tick) begin
        if (m_remain == 1) begin
          m_phase  = (m_phase + 1) % 6;
          m_remain = dur[m_phase];
          entered  = (m_phase == 2) || (m_phase == 5);
        end else if ((m_phase % 3 == 0) && m_ped && m_remain > int'(TGM)) begin
          m_remain = TGM;
        end else begin
          m_remain = m_remain - 1;
        end
      end
      m_ped       = ped_req || (m_ped && !entered);
      m_tick      = slow_clk && !m_prev_slow;
      m_prev_slow = slow_clk;
    end
  end

  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_ns",     32'(ns_lamp),  32'(m_ns[m_phase]));
      chk("mon_ew",     32'(ew_lamp),  32'(m_ew[m_phase]));
      chk("mon_remain", 32'(remain),   32'(m_remain));
      chk("mon_ped",    32'(ped_pend), 32'(m_ped));
      chk("mon_tick",   32'(tick),     32'(m_tick));
      chk("ns_onehot",  32'($onehot(ns_lamp)), 32'(1));
      chk("ew_onehot",  32'($onehot(ew_lamp)), 32'(1));
    end
  end

  // Waits for a tick strobe, then one more clk so the phase update is visible
  task automatic wait_tick(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL %s: no tick within 40 clk, expected one", name);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic       ped;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [7:0] rem;
  } vec_t;
  vec_t tbl[14];

  initial begin
    bit found;
    tbl[0]  = '{1'b0, 3'b001, 3'b100, 8'd3};
    tbl[1]  = '{1'b0, 3'b001, 3'b100, 8'd2};
    tbl[2]  = '{1'b0, 3'b001, 3'b100, 8'd1};
    tbl[3]  = '{1'b0, 3'b010, 3'b100, 8'd2};
    tbl[4]  = '{1'b0, 3'b010, 3'b100, 8'd1};
    tbl[5]  = '{1'b0, 3'b100, 3'b100, 8'd1};
    tbl[6]  = '{1'b0, 3'b100, 3'b001, 8'd4};
    tbl[7]  = '{1'b0, 3'b100, 3'b001, 8'd3};
    tbl[8]  = '{1'b0, 3'b100, 3'b001, 8'd2};
    tbl[9]  = '{1'b0, 3'b100, 3'b001, 8'd1};
    tbl[10] = '{1'b0, 3'b100, 3'b010, 8'd2};
    tbl[11] = '{1'b0, 3'b100, 3'b010, 8'd1};
    tbl[12] = '{1'b0, 3'b100, 3'b100, 8'd1};
    tbl[13] = '{1'b0, 3'b001, 3'b100, 8'd4};

    // 1: reset values
    rst_n = 1'b0; slow_run = 1'b0; slow_hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ns",     32'(ns_lamp),  32'(3'b001));
    chk("rst_ew",     32'(ew_lamp),  32'(3'b100));
    chk("rst_remain", 32'(remain),   32'(TG));
    chk("rst_ped",    32'(ped_pend), 32'(0));
    chk("rst_tick",   32'(tick),     32'(0));
    rst_n = 1'b1; slow_run = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    chk("first_clk_tick", 32'(tick), 32'(0));

    // 2: free run through a whole cycle
    for (int i = 0; i < 14; i++) begin
      ped_req = tbl[i].ped;
      wait_tick("free_run");
      chk($sformatf("tbl%0d_ns", i),     32'(ns_lamp), 32'(tbl[i].ns));
      chk($sformatf("tbl%0d_ew", i),     32'(ew_lamp), 32'(tbl[i].ew));
      chk($sformatf("tbl%0d_remain", i), 32'(remain),  32'(tbl[i].rem));
    end

    // 3: pedestrian pulse at NS green remain=4
    ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
    chk("ped_latched", 32'(ped_pend), 32'(1));
    wait_tick("ped_cut");
    chk("ped_cut_remain", 32'(remain), 32'(TGM));
    wait_tick("ped_cut1");
    chk("ped_cut1_remain", 32'(remain), 32'(1));
    wait_tick("ns_yellow");
    chk("ns_yellow_ns", 32'(ns_lamp),  32'(3'b010));
    chk("ns_yellow_ped", 32'(ped_pend), 32'(1));
    wait_tick("ns_yellow1");
    wait_tick("allred_a");
    chk("allred_a_ns",  32'(ns_lamp),  32'(3'b100));
    chk("allred_a_ped", 32'(ped_pend), 32'(0));

    // 4: request held across ALLRED_A entry; first find the next NS green start
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_tick("seek_ns_green");
      if (ns_lamp == 3'b001 && remain == 8'(TG)) begin
        found = 1'b1;
        break;
      end
    end
    chk("seek_ns_green", 32'(found), 32'(1));
    repeat (5) wait_tick("to_ns_yellow_end");
    chk("ns_y_end_remain", 32'(remain), 32'(1));
    chk("ns_y_end_ns",     32'(ns_lamp), 32'(3'b010));
    ped_req = 1'b1;
    wait_tick("held_allred_a");
    chk("held_allred_ped", 32'(ped_pend), 32'(1));
    chk("held_allred_ew",  32'(ew_lamp),  32'(3'b100));
    wait_tick("held_ew_green");
    ped_req = 1'b0;
    chk("held_ew_green_ew",  32'(ew_lamp), 32'(3'b001));
    chk("held_ew_green_rem", 32'(remain),  32'(TG));
    wait_tick("ew_cut");
    chk("ew_cut_remain", 32'(remain), 32'(TGM));
    wait_tick("ew_cut1");
    wait_tick("ew_yellow");
    chk("ew_yellow_ew", 32'(ew_lamp), 32'(3'b010));

    // 5: one-clk reset during EW yellow
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    chk("midrst_ns",     32'(ns_lamp),  32'(3'b001));
    chk("midrst_ew",     32'(ew_lamp),  32'(3'b100));
    chk("midrst_remain", 32'(remain),   32'(TG));
    chk("midrst_ped",    32'(ped_pend), 32'(0));

    // 6: slow_clk high at reset release gives no tick
    rst_n = 1'b0; slow_run = 1'b0; slow_hold = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("slow_high_no_tick", 32'(tick), 32'(0));
    end
    slow_run = 1'b1;
    wait_tick("first_real_tick");
    chk("first_real_tick_remain", 32'(remain), 32'(TG - 1));

    // Randomized pedestrian traffic with occasional resets
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      ped_req = ($urandom_range(0, 15) == 0);
      rst_n   = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1; ped_req = 1'b0;
    repeat (4) @(negedge clk);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
